// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling from a free-running baud-tick divider.
// Each good frame updates o_data and pulses o_done; a low stop bit pulses o_frame_err.
module uart_rx #(
    parameter int CLK_FREQ     = 50000000,
    parameter int BAUD_RATE    = 19200,
    parameter int PAYLOAD_SIZE = 8,
    parameter int OVERSAMPLE   = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_rx,
    output logic [PAYLOAD_SIZE-1:0] o_data,
    output logic                    o_done,
    output logic                    o_frame_err,
    output logic                    o_busy
);

    localparam int DIV = (CLK_FREQ + 8 * BAUD_RATE) / (16 * BAUD_RATE);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int NW  = (PAYLOAD_SIZE > 1) ? $clog2(PAYLOAD_SIZE) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [NW-1:0] N_LAST   = NW'(PAYLOAD_SIZE - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_e;

    state_e                  state_q, state_d;
    logic [DW-1:0]           div_q;
    logic [3:0]              s_q, s_d;
    logic [NW-1:0]           n_q, n_d;
    logic [PAYLOAD_SIZE-1:0] shift_q, shift_d;
    logic [PAYLOAD_SIZE-1:0] data_q, data_d;
    logic                    done_q, done_d;
    logic                    ferr_q, ferr_d;
    logic                    rx_meta_q, rx_s_q;
    logic                    tick;

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= i_rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Free-running divider, deliberately not re-phased on a start edge.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) div_q <= '0;
        else if (div_q == DIV_LAST) div_q <= '0;
        else div_q <= div_q + 1'b1;
    end

    assign tick = (div_q == DIV_LAST);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            shift_q <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        shift_d = shift_q;
        data_d  = data_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                // Re-check the line half a bit in to reject glitches.
                if (tick) begin
                    if (s_q == 4'd7) begin
                        if (!rx_s_q) begin
                            state_d = DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_q == 4'd15) begin
                        shift_d = {rx_s_q, shift_q[PAYLOAD_SIZE-1:1]};
                        s_d     = '0;
                        if (n_q == N_LAST) state_d = STOP;
                        else n_d = n_q + 1'b1;
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (s_q == 4'd15) begin
                        if (rx_s_q) begin
                            data_d  = shift_q;
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = BREAK;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            BREAK: begin
                // A held-low line must go high before another start is accepted.
                if (rx_s_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_data      = data_q;
    assign o_done      = done_q;
    assign o_frame_err = ferr_q;
    assign o_busy      = (state_q != IDLE);

endmodule
